// File: rtl/theremin_audio_pkg.sv
// Shared types and constants for the theremin per-sample audio scheduler.
package theremin_audio_pkg;

   localparam int unsigned SAMPLE_W_DEFAULT   = 24;
   localparam int unsigned SAMPLE_PERIOD_CLKS = 3072;

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StWait,
      StLoad,
      StAck,
      StDone
   } audio_sched_state_t;

   typedef struct packed {
      logic [SAMPLE_W_DEFAULT-1:0] l0;
      logic [SAMPLE_W_DEFAULT-1:0] r0;
      logic [SAMPLE_W_DEFAULT-1:0] l1;
      logic [SAMPLE_W_DEFAULT-1:0] r1;
   } audio_frame_t;

endpackage

// File: rtl/theremin_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; clear has priority over inc.
module theremin_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/theremin_audio_sample_sched.sv
// Per-sample scheduler: captures Line In, fetches a synth frame by REQ/READY,
// loads the audio_io output registers and acknowledges the IRQ within a bounded time.
module theremin_audio_sample_sched
   import theremin_audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W       = SAMPLE_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 2048,
   parameter int unsigned UNDERRUN_W     = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  IRQ,
   output logic                  ACK,
   input  logic [SAMPLE_W-1:0]   IN_LEFT_CHANNEL,
   input  logic [SAMPLE_W-1:0]   IN_RIGHT_CHANNEL,
   output logic [SAMPLE_W-1:0]   OUT_LEFT_CHANNEL0,
   output logic [SAMPLE_W-1:0]   OUT_RIGHT_CHANNEL0,
   output logic [SAMPLE_W-1:0]   OUT_LEFT_CHANNEL1,
   output logic [SAMPLE_W-1:0]   OUT_RIGHT_CHANNEL1,
   output logic                  SAMPLE_REQ,
   input  logic                  SAMPLE_READY,
   input  logic [SAMPLE_W-1:0]   SRC_L0,
   input  logic [SAMPLE_W-1:0]   SRC_R0,
   input  logic [SAMPLE_W-1:0]   SRC_L1,
   input  logic [SAMPLE_W-1:0]   SRC_R1,
   output logic [SAMPLE_W-1:0]   LINE_IN_LEFT,
   output logic [SAMPLE_W-1:0]   LINE_IN_RIGHT,
   output logic                  LINE_IN_VALID,
   input  logic                  MUTE,
   output logic [UNDERRUN_W-1:0] UNDERRUN_COUNT,
   output logic                  BUSY
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES + 3 >= SAMPLE_PERIOD_CLKS)) begin : g_bound_err
      $error("TIMEOUT_CYCLES must be nonzero and leave IRQ-to-ACK inside one sample period");
   end

   audio_sched_state_t state_q;
   logic                irq_q;
   logic [CntW-1:0]     tmo_cnt_q;
   logic                ack_q;
   logic                req_q;
   logic                lin_valid_q;
   logic                busy_q;
   logic [SAMPLE_W-1:0] lin_l_q, lin_r_q;
   logic [SAMPLE_W-1:0] out_l0_q, out_r0_q, out_l1_q, out_r1_q;

   logic req_phase;
   logic ready_seen;
   logic timeout;

   // The capture cycle already drives SAMPLE_REQ, so it is the first cycle of the request window.
   always_comb begin
      req_phase  = (state_q == StCapture) || (state_q == StWait);
      ready_seen = req_phase && SAMPLE_READY;
      timeout    = req_phase && !SAMPLE_READY && (tmo_cnt_q == CntLast);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= StIdle;
         irq_q       <= 1'b0;
         tmo_cnt_q   <= '0;
         ack_q       <= 1'b0;
         req_q       <= 1'b0;
         lin_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         lin_l_q     <= '0;
         lin_r_q     <= '0;
         out_l0_q    <= '0;
         out_r0_q    <= '0;
         out_l1_q    <= '0;
         out_r1_q    <= '0;
      end else begin
         irq_q       <= IRQ;
         lin_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (IRQ && !irq_q) begin
                  state_q     <= StCapture;
                  lin_l_q     <= IN_LEFT_CHANNEL;
                  lin_r_q     <= IN_RIGHT_CHANNEL;
                  lin_valid_q <= 1'b1;
                  req_q       <= 1'b1;
                  tmo_cnt_q   <= '0;
                  busy_q      <= 1'b1;
               end
            end
            StCapture, StWait: begin
               if (ready_seen) begin
                  state_q  <= StLoad;
                  req_q    <= 1'b0;
                  out_l0_q <= MUTE ? '0 : SRC_L0;
                  out_r0_q <= MUTE ? '0 : SRC_R0;
                  out_l1_q <= MUTE ? '0 : SRC_L1;
                  out_r1_q <= MUTE ? '0 : SRC_R1;
               end else if (timeout) begin
                  // Underrun: repeat the previous frame unless muted.
                  state_q <= StLoad;
                  req_q   <= 1'b0;
                  if (MUTE) begin
                     out_l0_q <= '0;
                     out_r0_q <= '0;
                     out_l1_q <= '0;
                     out_r1_q <= '0;
                  end
               end else begin
                  state_q   <= StWait;
                  tmo_cnt_q <= tmo_cnt_q + CntW'(1);
               end
            end
            StLoad: begin
               state_q <= StAck;
               ack_q   <= 1'b1;
            end
            StAck: begin
               state_q <= StDone;
            end
            StDone: begin
               if (!IRQ) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   theremin_sat_counter #(
      .WIDTH (UNDERRUN_W)
   ) u_underrun_cnt (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .inc_i   (timeout),
      .clear_i (1'b0),
      .count_o (UNDERRUN_COUNT)
   );

   assign ACK                = ack_q;
   assign SAMPLE_REQ         = req_q;
   assign LINE_IN_VALID      = lin_valid_q;
   assign BUSY               = busy_q;
   assign LINE_IN_LEFT       = lin_l_q;
   assign LINE_IN_RIGHT      = lin_r_q;
   assign OUT_LEFT_CHANNEL0  = out_l0_q;
   assign OUT_RIGHT_CHANNEL0 = out_r0_q;
   assign OUT_LEFT_CHANNEL1  = out_l1_q;
   assign OUT_RIGHT_CHANNEL1 = out_r1_q;

endmodule

// File: tb/tb_theremin_audio_sample_sched.sv
// Randomized self-checking bench for theremin_audio_sample_sched against a transaction-level model.
module tb_theremin_audio_sample_sched;
   import theremin_audio_pkg::*;

   localparam int unsigned SW     = 24;
   localparam int unsigned TO     = 16;
   localparam int unsigned UW     = 4;
   localparam int          UR_MAX = (1 << UW) - 1;

   logic          clk;
   logic          rst;
   logic          irq;
   logic          ack;
   logic [SW-1:0] in_l, in_r;
   logic [SW-1:0] out_l0, out_r0, out_l1, out_r1;
   logic          req;
   logic          ready;
   audio_frame_t  src_f;
   logic [SW-1:0] lin_l, lin_r;
   logic          lin_valid;
   logic          mute_in;
   logic [UW-1:0] underrun;
   logic          busy;

   int            n_checks;
   int            n_fail;
   audio_frame_t  frame_exp;
   int            underrun_exp;
   logic [SW-1:0] in_l_exp, in_r_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   theremin_audio_sample_sched #(
      .SAMPLE_W       (SW),
      .TIMEOUT_CYCLES (TO),
      .UNDERRUN_W     (UW)
   ) dut (
      .CLK                (clk),
      .RESET              (rst),
      .IRQ                (irq),
      .ACK                (ack),
      .IN_LEFT_CHANNEL    (in_l),
      .IN_RIGHT_CHANNEL   (in_r),
      .OUT_LEFT_CHANNEL0  (out_l0),
      .OUT_RIGHT_CHANNEL0 (out_r0),
      .OUT_LEFT_CHANNEL1  (out_l1),
      .OUT_RIGHT_CHANNEL1 (out_r1),
      .SAMPLE_REQ         (req),
      .SAMPLE_READY       (ready),
      .SRC_L0             (src_f.l0),
      .SRC_R0             (src_f.r0),
      .SRC_L1             (src_f.l1),
      .SRC_R1             (src_f.r1),
      .LINE_IN_LEFT       (lin_l),
      .LINE_IN_RIGHT      (lin_r),
      .LINE_IN_VALID      (lin_valid),
      .MUTE               (mute_in),
      .UNDERRUN_COUNT     (underrun),
      .BUSY               (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [SW-1:0] rnd_sample();
      return SW'($urandom());
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_src();
      src_f.l0 = rnd_sample();
      src_f.r0 = rnd_sample();
      src_f.l1 = rnd_sample();
      src_f.r1 = rnd_sample();
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_out_l0"}, 32'(out_l0), 32'(frame_exp.l0));
      check({tag, "_out_r0"}, 32'(out_r0), 32'(frame_exp.r0));
      check({tag, "_out_l1"}, 32'(out_l1), 32'(frame_exp.l1));
      check({tag, "_out_r1"}, 32'(out_r1), 32'(frame_exp.r1));
   endtask

   task automatic check_reset_values();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_lin_valid", 32'(lin_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_lin_l", 32'(lin_l), 32'd0);
      check("rst_lin_r", 32'(lin_r), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      frame_exp    = '0;
      underrun_exp = 0;
      check_frame("rst");
   endtask

   // Raise IRQ with the given Line In pair; returns in the first cycle after the IRQ edge.
   task automatic begin_irq(input logic [SW-1:0] l, input logic [SW-1:0] r);
      in_l     = l;
      in_r     = r;
      in_l_exp = l;
      in_r_exp = r;
      irq      = 1'b1;
      step();
      in_l = rnd_sample();
      in_r = rnd_sample();
   endtask

   // ready_at: 1-based request cycle carrying READY, 0 or >TO means the synth never answers.
   // mute_mode: 0 off, 1 on, 2 random per cycle.
   task automatic service(input int ready_at, input bit fixed_en, input audio_frame_t fixed,
                          input int mute_mode);
      bit hit;
      bit m;
      int n;
      int hold;
      hit = (ready_at >= 1) && (ready_at <= int'(TO));
      n   = hit ? ready_at : int'(TO);
      for (int k = 1; k <= n; k++) begin
         check("req_high", 32'(req), 32'd1);
         check("lin_valid", 32'(lin_valid), 32'(k == 1));
         check("ack_early", 32'(ack), 32'd0);
         if (k == 1) begin
            check("lin_l", 32'(lin_l), 32'(in_l_exp));
            check("lin_r", 32'(lin_r), 32'(in_r_exp));
            check("busy_req", 32'(busy), 32'd1);
         end
         m       = (mute_mode == 2) ? 1'($urandom_range(0, 1)) : (mute_mode == 1);
         mute_in = m;
         ready   = (k == ready_at);
         randomize_src();
         if ((k == ready_at) && fixed_en) src_f = fixed;
         if (k == n) begin
            if (hit) begin
               frame_exp = m ? '0 : src_f;
            end else begin
               if (m) frame_exp = '0;
               if (underrun_exp < UR_MAX) underrun_exp++;
            end
         end
         step();
      end
      ready   = 1'b0;
      mute_in = 1'($urandom_range(0, 1));
      randomize_src();
      check("req_dropped", 32'(req), 32'd0);
      check("ack_before", 32'(ack), 32'd0);
      check("underrun", 32'(underrun), 32'(underrun_exp));
      check_frame("load");
      step();
      check("ack_pulse", 32'(ack), 32'd1);
      check("busy_ack", 32'(busy), 32'd1);
      step();
      check("ack_single", 32'(ack), 32'd0);
      check("busy_done", 32'(busy), 32'd1);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
         ready = 1'($urandom_range(0, 1));
         step();
         check("no_retrigger_req", 32'(req), 32'd0);
         check("no_retrigger_ack", 32'(ack), 32'd0);
      end
      irq   = 1'b0;
      ready = 1'b0;
      step();
      check("busy_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 2; i++) begin
         ready = 1'($urandom_range(0, 1));
         randomize_src();
         step();
         check("idle_req", 32'(req), 32'd0);
      end
      ready = 1'b0;
      check_frame("idle_hold");
   endtask

   initial begin
      audio_frame_t f;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      irq      = 1'b0;
      ready    = 1'b0;
      mute_in  = 1'b0;
      in_l     = '0;
      in_r     = '0;
      src_f    = '0;
      repeat (3) step();
      check_reset_values();
      rst = 1'b0;
      step();

      // Normal frame: READY ten cycles after SAMPLE_REQ rises.
      f.l0 = 24'haaaaaa;
      f.r0 = 24'h555555;
      f.l1 = 24'hffffff;
      f.r1 = 24'h000000;
      begin_irq(rnd_sample(), rnd_sample());
      service(11, 1'b1, f, 0);

      // Loopback capture.
      begin_irq(24'hcdef11, 24'h654321);
      service($urandom_range(1, TO), 1'b0, '0, 0);

      // Timeout holds previous frame; then READY on the last request cycle.
      begin_irq(rnd_sample(), rnd_sample());
      service(0, 1'b0, '0, 0);
      begin_irq(rnd_sample(), rnd_sample());
      service(TO, 1'b0, '0, 0);

      // Mute.
      f.l0 = 24'h123456;
      f.r0 = 24'hcccccc;
      f.l1 = 24'h333333;
      f.r1 = 24'hcccccc;
      begin_irq(rnd_sample(), rnd_sample());
      service(5, 1'b1, f, 1);

      for (int t = 0; t < 20; t++) begin
         begin_irq(rnd_sample(), rnd_sample());
         service($urandom_range(0, TO + 4), 1'b0, '0, 2);
      end

      // Reset in the middle of WAIT with IRQ held high.
      begin_irq(rnd_sample(), rnd_sample());
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      step();
      check_reset_values();
      in_l     = rnd_sample();
      in_r     = rnd_sample();
      in_l_exp = in_l;
      in_r_exp = in_r;
      rst      = 1'b0;
      step();
      service($urandom_range(1, TO), 1'b0, '0, 0);

      // Saturation of the underrun counter.
      for (int t = 0; t < UR_MAX + 2; t++) begin
         begin_irq(rnd_sample(), rnd_sample());
         service(0, 1'b0, '0, 2);
      end
      check("underrun_saturated", 32'(underrun), 32'(UR_MAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
